// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, sequences instruction-memory requests and holds the
// fetched word for decode until the consumer advances or a flush redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      next_pc_in,
   input  logic             advance,
   input  logic             flush,
   input  logic [31:0]      flush_pc,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc_out,
   output logic [31:0]      instr_out,
   output logic             instr_valid,
   output logic             misalign_err,
   output logic [CNT_W-1:0] retired_cnt
);
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;
   state_t           r_state, w_state;
   logic [31:0]      r_pc, r_addr, r_instr, w_pc, w_addr, w_instr, w_fpc;
   logic             r_err, w_err;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   assign w_fpc = {flush_pc[31:2], 2'b00};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_instr <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state;
         r_pc    <= w_pc;
         r_addr  <= w_addr;
         r_instr <= w_instr;
         r_err   <= w_err;
         r_cnt   <= w_cnt;
      end
   end
   always_comb begin
      w_state = r_state;
      w_pc    = r_pc;
      w_addr  = r_addr;
      w_instr = r_instr;
      w_err   = r_err;
      w_cnt   = r_cnt;
      case (r_state)
         FETCH: begin
            if (flush) begin
               w_pc = w_fpc;
               // a redirect racing an unfinished request must wait for it in DRAIN
               if (imem_ready) w_addr = w_fpc;
               else w_state = DRAIN;
            end else if (imem_ready) begin
               w_instr = imem_rdata;
               w_state = HOLD;
            end
         end
         HOLD: begin
            if (flush) begin
               w_pc    = w_fpc;
               w_addr  = w_fpc;
               w_state = FETCH;
            end else if (advance) begin
               if (|next_pc_in[1:0]) begin
                  w_err   = 1'b1;
                  w_state = HALT;
               end else begin
                  w_pc    = next_pc_in;
                  w_addr  = next_pc_in;
                  w_cnt   = r_cnt + CNT_W'(1);
                  w_state = FETCH;
               end
            end
         end
         DRAIN: begin
            if (flush) w_pc = w_fpc;
            if (imem_ready) begin
               w_addr  = w_pc;
               w_state = FETCH;
            end
         end
         default: ;
      endcase
   end
   assign imem_req     = (r_state == FETCH) || (r_state == DRAIN);
   assign imem_addr    = r_addr;
   assign pc_out       = r_pc;
   assign instr_out    = r_instr;
   assign instr_valid  = (r_state == HOLD);
   assign misalign_err = r_err;
   assign retired_cnt  = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected (pc, instr)
// pairs, popped whenever instr_valid rises.
module tb_fetch_unit;
   logic        clk = 0, rst = 1, advance = 0, flush = 0, imem_ready = 0;
   logic [31:0] next_pc_in = 0, flush_pc = 0, imem_rdata = 0;
   logic        imem_req, instr_valid, misalign_err;
   logic [31:0] imem_addr, pc_out, instr_out;
   logic [3:0]  retired_cnt;
   logic [3:0]  m_cnt = 0;
   logic [31:0] m_pc = 0;
   logic [63:0] exp_q[$];
   logic [63:0] e;
   logic        r_pv = 0;
   int          n_cmp = 0, n_bad = 0;

   fetch_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .next_pc_in(next_pc_in), .advance(advance),
      .flush(flush), .flush_pc(flush_pc), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid),
      .misalign_err(misalign_err), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] data);
      chk("req", {31'b0, imem_req}, 1);
      chk("addr", imem_addr, m_pc);
      exp_q.push_back({m_pc, data});
      imem_ready = 1;
      imem_rdata = data;
      tick;
      imem_ready = 0;
      chk("valid", {31'b0, instr_valid}, 1);
   endtask

   task automatic adv(input logic [31:0] npc);
      advance = 1;
      next_pc_in = npc;
      tick;
      advance = 0;
      m_pc = npc;
      m_cnt = m_cnt + 4'd1;
      chk("cnt", {28'b0, retired_cnt}, {28'b0, m_cnt});
      chk("pc_adv", pc_out, m_pc);
      chk("valid_clr", {31'b0, instr_valid}, 0);
   endtask

   always @(negedge clk) begin
      if (instr_valid && !r_pv) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc_out, e[63:32]);
            chk("sb_instr", instr_out, e[31:0]);
         end
      end
      r_pv = instr_valid;
   end

   initial begin
      tick; tick;
      chk("rst_pc", pc_out, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", {31'b0, instr_valid}, 0);
      chk("rst_cnt", {28'b0, retired_cnt}, 0);
      chk("rst_err", {31'b0, misalign_err}, 0);
      rst = 0;
      tick;
      // zero-wait fetch then advance to 4
      fetch(32'h2002_0005);
      adv(32'h4);
      // stall in HOLD
      fetch(32'h1111_1111);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("stall_pc", pc_out, 32'h4);
         chk("stall_instr", instr_out, 32'h1111_1111);
         chk("stall_valid", {31'b0, instr_valid}, 1);
         chk("stall_req", {31'b0, imem_req}, 0);
         chk("stall_cnt", {28'b0, retired_cnt}, {28'b0, m_cnt});
      end
      adv(32'h8);
      // flush while request outstanding -> DRAIN
      flush = 1; flush_pc = 32'h100;
      tick;
      flush = 0;
      chk("drain_addr", imem_addr, 32'h8);
      chk("drain_pc", pc_out, 32'h100);
      for (int i = 0; i < 2; i++) begin
         tick;
         chk("drain_hold", imem_addr, 32'h8);
         chk("drain_req", {31'b0, imem_req}, 1);
      end
      imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
      tick;
      imem_ready = 0;
      chk("drain_valid", {31'b0, instr_valid}, 0);
      m_pc = 32'h100;
      fetch(32'h2222_2222);
      // flush beats advance in HOLD
      flush = 1; flush_pc = 32'h203; advance = 1; next_pc_in = 32'h40;
      tick;
      flush = 0; advance = 0;
      chk("fa_pc", pc_out, 32'h200);
      chk("fa_addr", imem_addr, 32'h200);
      chk("fa_cnt", {28'b0, retired_cnt}, {28'b0, m_cnt});
      m_pc = 32'h200;
      // flush with same-cycle ready in FETCH drops the response
      flush = 1; flush_pc = 32'h301; imem_ready = 1; imem_rdata = 32'hBAD0_BAD0;
      tick;
      flush = 0; imem_ready = 0;
      chk("fr_addr", imem_addr, 32'h300);
      chk("fr_valid", {31'b0, instr_valid}, 0);
      m_pc = 32'h300;
      // counter wrap across 16 advances
      for (int i = 0; i < 16; i++) begin
         fetch(32'h5000_0000 + i);
         adv(m_pc + 32'h4);
      end
      // misaligned advance halts
      fetch(32'h3333_3333);
      advance = 1; next_pc_in = 32'h42;
      tick;
      advance = 0;
      chk("mis_err", {31'b0, misalign_err}, 1);
      chk("mis_req", {31'b0, imem_req}, 0);
      chk("mis_valid", {31'b0, instr_valid}, 0);
      flush = 1; flush_pc = 32'h500;
      tick; tick;
      flush = 0;
      chk("halt_req", {31'b0, imem_req}, 0);
      chk("halt_pc", pc_out, m_pc);
      chk("halt_err", {31'b0, misalign_err}, 1);
      rst = 1;
      tick;
      chk("rst2_err", {31'b0, misalign_err}, 0);
      chk("rst2_pc", pc_out, 0);
      chk("rst2_cnt", {28'b0, retired_cnt}, 0);
      rst = 0;
      m_pc = 0; m_cnt = 0;
      tick;
      fetch(32'h4444_4444);
      adv(32'h4);
      tick;
      chk("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
